instr_fetch_buf: RTL and testbench

INSTR_FETCH_BUF -- requirements
Module: instr_fetch_buf

---
 rtl/instr_fetch_buf_pkg.sv | 24 ++
 rtl/instr_fetch_buf_prog_mem.sv | 30 +++
 rtl/instr_fetch_buf.sv | 126 ++++++++++++
 tb/tb_instr_fetch_buf.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_buf_pkg.sv
// Shared definitions for the instruction fetch buffer:
// FSM state encoding, default sizing, and the instruction byte layout.
package instr_fetch_buf_pkg;

    localparam int unsigned IFB_DEPTH_DEFAULT = 16;
    localparam logic [7:0]  IFB_FILL_DEFAULT  = 8'h00;
    localparam int unsigned INSTR_W           = 8;

    // Encoding 2'd3 is unused; the FSM recovers from it to ST_IDLE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    // Program byte layout: {opcode[7:6], reg0[5:4], reg1[3:2], spare[1:0]}.
    typedef struct packed {
        logic [1:0] opcode;
        logic [1:0] reg0;
        logic [1:0] reg1;
        logic [1:0] spare;
    } instr_t;

endpackage

// File: rtl/instr_fetch_buf_prog_mem.sv
// Program storage: DEPTH x 8 bits, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports: clk, we/waddr/wdata (write), raddr/rdata_c (combinational read).
module instr_fetch_buf_prog_mem
    import instr_fetch_buf_pkg::*;
#(
    parameter  int unsigned DEPTH = IFB_DEPTH_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  instr_t        wdata,
    input  logic [AW-1:0] raddr,
    output instr_t        rdata_c
);

    instr_t mem [DEPTH];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Asynchronous read port.
    assign rdata_c = mem[raddr];

endmodule

// File: rtl/instr_fetch_buf.sv
// Instruction fetch buffer: a program is loaded byte-by-byte in LOAD, then
// in RUN the byte addressed by pc_in is issued one cycle later.
// Ports:
//   clk, rst (async, active-low)
//   load_en/load_valid/load_data/load_ready : program load handshake
//   run_start/hold/pc_in                    : run control and fetch address
//   instr_out/instr_valid                   : registered fetch result
//   prog_len/state                          : program length and FSM state
module instr_fetch_buf
    import instr_fetch_buf_pkg::*;
#(
    parameter  int unsigned DEPTH = IFB_DEPTH_DEFAULT,
    parameter  logic [7:0]  FILL  = IFB_FILL_DEFAULT,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_en,
    input  logic          load_valid,
    input  logic [7:0]    load_data,
    output logic          load_ready,
    input  logic          run_start,
    input  logic          hold,
    input  logic [7:0]    pc_in,
    output logic [7:0]    instr_out,
    output logic          instr_valid,
    output logic [LW-1:0] prog_len,
    output logic [1:0]    state
);

    state_e          state_q;
    state_e          state_d;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   len_d;
    logic [7:0]      out_d;
    logic            vld_d;
    logic            we;
    logic [AW-1:0]   idx;
    logic            hit;
    instr_t          rdata_c;

    // Load handshake: accept only in LOAD while not full.
    assign load_ready = (state_q == ST_LOAD) && (len_q < LW'(DEPTH));
    assign we         = load_valid && load_ready;

    // Fetch address wraps by truncation; slots beyond prog_len are masked.
    assign idx = AW'(pc_in);
    assign hit = {1'b0, idx} < len_q;

    instr_fetch_buf_prog_mem #(
        .DEPTH (DEPTH)
    ) prog_mem (
        .clk     (clk),
        .we      (we),
        .waddr   (len_q[AW-1:0]),
        .wdata   (instr_t'(load_data)),
        .raddr   (idx),
        .rdata_c (rdata_c)
    );

    // State, length counter and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            instr_out   <= FILL;
            instr_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            instr_out   <= out_d;
            instr_valid <= vld_d;
        end
    end

    // Next-state and program length; load_en wins over run_start in IDLE.
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (load_en) begin
                    state_d = ST_LOAD;
                    len_d   = '0;
                end else if (run_start && (len_q != '0)) begin
                    state_d = ST_RUN;
                end
            end
            ST_LOAD: begin
                if (we) begin
                    len_d = len_q + LW'(1);
                end
                if (!load_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (load_en) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output next values: fetch only while staying in RUN, so the edge
    // leaving RUN already issues FILL.
    always_comb begin
        out_d = FILL;
        vld_d = 1'b0;
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            if (hold) begin
                out_d = instr_out;
                vld_d = instr_valid;
            end else begin
                out_d = hit ? rdata_c : FILL;
                vld_d = hit;
            end
        end
    end

    assign prog_len = len_q;
    assign state    = state_q;

endmodule

// File: tb/tb_instr_fetch_buf.sv
// Directed bench for instr_fetch_buf: a table of one-edge vectors plus
// hand-written sequences for overfill and asynchronous reset mid-RUN.
module tb_instr_fetch_buf;

    logic       clk = 1'b0;
    logic       rst;
    logic       load_en;
    logic       load_valid;
    logic [7:0] load_data;
    logic       load_ready;
    logic       run_start;
    logic       hold;
    logic [7:0] pc_in;
    logic [7:0] instr_out;
    logic       instr_valid;
    logic [4:0] prog_len;
    logic [1:0] state;

    int n_vec = 0;
    int n_err = 0;

    instr_fetch_buf dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .load_ready  (load_ready),
        .run_start   (run_start),
        .hold        (hold),
        .pc_in       (pc_in),
        .instr_out   (instr_out),
        .instr_valid (instr_valid),
        .prog_len    (prog_len),
        .state       (state)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       le;
        logic       lv;
        logic [7:0] d;
        logic       rs;
        logic       hd;
        logic [7:0] pc;
        logic [1:0] st;
        logic [7:0] out;
        logic       vld;
        logic [4:0] len;
        logic       rdy;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic le, input logic lv, input logic [7:0] d,
                       input logic rs, input logic hd, input logic [7:0] pc,
                       input logic [1:0] st, input logic [7:0] out,
                       input logic vld, input logic [4:0] len, input logic rdy);
        vec_t v;
        v.le = le; v.lv = lv; v.d = d; v.rs = rs; v.hd = hd; v.pc = pc;
        v.st = st; v.out = out; v.vld = vld; v.len = len; v.rdy = rdy;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic drive(input logic le, input logic lv, input logic [7:0] d,
                         input logic rs, input logic hd, input logic [7:0] pc);
        load_en = le; load_valid = lv; load_data = d;
        run_start = rs; hold = hd; pc_in = pc;
    endtask

    // Apply inputs at the falling edge, take one rising edge, sample at the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_all(input string nm, input logic [1:0] st, input logic [7:0] out,
                           input logic vld, input logic [4:0] len, input logic rdy);
        chk({nm, ".state"}, 32'(state), 32'(st));
        chk({nm, ".instr_out"}, 32'(instr_out), 32'(out));
        chk({nm, ".instr_valid"}, 32'(instr_valid), 32'(vld));
        chk({nm, ".prog_len"}, 32'(prog_len), 32'(len));
        chk({nm, ".load_ready"}, 32'(load_ready), 32'(rdy));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //     le lv d      rs hd pc     | st out    vld len rdy
        add(1, 0, 8'h00, 1, 0, 8'h00,   1, 8'h00, 0, 0, 1); // load_en beats run_start
        add(1, 1, 8'h41, 0, 0, 8'h00,   1, 8'h00, 0, 1, 1);
        add(1, 1, 8'h92, 0, 0, 8'h00,   1, 8'h00, 0, 2, 1);
        add(1, 1, 8'hE3, 0, 0, 8'h00,   1, 8'h00, 0, 3, 1);
        add(0, 0, 8'h00, 0, 0, 8'h00,   0, 8'h00, 0, 3, 0);
        add(0, 0, 8'h00, 1, 0, 8'h00,   2, 8'h00, 0, 3, 0); // enter RUN, still FILL
        add(0, 0, 8'h00, 0, 0, 8'h00,   2, 8'h41, 1, 3, 0);
        add(0, 0, 8'h00, 0, 0, 8'h01,   2, 8'h92, 1, 3, 0);
        add(0, 0, 8'h00, 0, 0, 8'h02,   2, 8'hE3, 1, 3, 0);
        add(0, 0, 8'h00, 0, 0, 8'h03,   2, 8'h00, 0, 3, 0); // beyond prog_len
        add(0, 0, 8'h00, 0, 0, 8'h12,   2, 8'hE3, 1, 3, 0); // pc wraps to 2
        add(0, 0, 8'h00, 0, 0, 8'h10,   2, 8'h41, 1, 3, 0); // pc wraps to 0
        add(0, 0, 8'h00, 0, 1, 8'h01,   2, 8'h41, 1, 3, 0); // hold
        add(0, 0, 8'h00, 0, 1, 8'h02,   2, 8'h41, 1, 3, 0);
        add(0, 0, 8'h00, 0, 1, 8'h03,   2, 8'h41, 1, 3, 0);
        add(0, 0, 8'h00, 0, 0, 8'h01,   2, 8'h92, 1, 3, 0); // release
        add(0, 0, 8'h00, 1, 0, 8'h02,   2, 8'hE3, 1, 3, 0); // run_start ignored
        add(1, 0, 8'h00, 0, 1, 8'h00,   0, 8'h00, 0, 3, 0); // abort, FILL despite hold
        add(0, 0, 8'h00, 1, 0, 8'h00,   2, 8'h00, 0, 3, 0);
        add(0, 0, 8'h00, 0, 0, 8'h00,   2, 8'h41, 1, 3, 0); // program survives abort
        add(1, 0, 8'h00, 0, 0, 8'h00,   0, 8'h00, 0, 3, 0);
        add(1, 0, 8'h00, 0, 0, 8'h00,   1, 8'h00, 0, 0, 1); // reload clears length
        add(1, 1, 8'h5A, 0, 0, 8'h00,   1, 8'h00, 0, 1, 1);
        add(0, 0, 8'h00, 0, 0, 8'h00,   0, 8'h00, 0, 1, 0);
        add(0, 1, 8'hFF, 0, 0, 8'h00,   0, 8'h00, 0, 1, 0); // no write outside LOAD
        add(0, 0, 8'h00, 1, 0, 8'h00,   2, 8'h00, 0, 1, 0);
        add(0, 0, 8'h00, 0, 0, 8'h00,   2, 8'h5A, 1, 1, 0);
        add(0, 0, 8'h00, 0, 0, 8'h01,   2, 8'h00, 0, 1, 0); // stale slot masked
        add(0, 0, 8'h00, 0, 0, 8'h04,   2, 8'h00, 0, 1, 0);

        rst = 1'b1;
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        #1 rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk_all("reset", 2'd0, 8'h00, 1'b0, 5'd0, 1'b0);
        rst = 1'b1;

        foreach (tbl[i]) begin
            drive(tbl[i].le, tbl[i].lv, tbl[i].d, tbl[i].rs, tbl[i].hd, tbl[i].pc);
            step();
            chk_all($sformatf("v%0d", i), tbl[i].st, tbl[i].out, tbl[i].vld, tbl[i].len, tbl[i].rdy);
        end

        // Overfill: 17 bytes with load_valid held high.
        drive(1, 0, 8'h00, 0, 0, 8'h00);
        step();
        step();
        chk("fill.enter", 32'(state), 32'd1);
        for (int k = 0; k < 17; k++) begin
            drive(1, 1, 8'(8'hA0 + k), 0, 0, 8'h00);
            step();
            if (k == 14) begin
                chk("fill.len15", 32'(prog_len), 32'd15);
                chk("fill.rdy15", 32'(load_ready), 32'd1);
            end
            if (k >= 15) begin
                chk($sformatf("fill.len_k%0d", k), 32'(prog_len), 32'd16);
                chk($sformatf("fill.rdy_k%0d", k), 32'(load_ready), 32'd0);
            end
        end
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        step();
        drive(0, 0, 8'h00, 1, 0, 8'h00);
        step();
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        step();
        chk_all("fill.pc0", 2'd2, 8'hA0, 1'b1, 5'd16, 1'b0);
        drive(0, 0, 8'h00, 0, 0, 8'h0F);
        step();
        chk_all("fill.pc15", 2'd2, 8'hAF, 1'b1, 5'd16, 1'b0);
        drive(0, 0, 8'h00, 0, 0, 8'hF0);
        step();
        chk_all("fill.pcF0", 2'd2, 8'hA0, 1'b1, 5'd16, 1'b0);

        // Asynchronous reset between edges while running.
        #2 rst = 1'b0;
        #1;
        chk_all("arst", 2'd0, 8'h00, 1'b0, 5'd0, 1'b0);
        #1 rst = 1'b1;
        drive(0, 0, 8'h00, 1, 0, 8'h00);
        @(negedge clk);
        chk_all("arst.run_empty", 2'd0, 8'h00, 1'b0, 5'd0, 1'b0);
        drive(0, 0, 8'h00, 0, 0, 8'h00);
        step();
        chk_all("arst.idle", 2'd0, 8'h00, 1'b0, 5'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
